spi_ram_ctrl: RTL and testbench
===============================

// Module: spi_ram_ctrl
// PURPOSE
//  Command-decoding single-port RAM that sits directly downstream of the SPI slave.
//  - Consumes the slave's 10-bit rx_data/rx_valid words and performs address-load, write and read operations.
//  - Returns read bytes on dout/tx_valid for the slave to shift out on MISO.
//  - Word format: din[9:8] = command, din[7:0] = address or data.
// PARAMETERS
//  MEM_DEPTH  256  number of 8-bit words; legal range 2..256
//  ADDR_SIZE  8    address register width; must satisfy 2**ADDR_SIZE >= MEM_DEPTH, ADDR_SIZE <= 8
//  AUTO_INC   0    1: wr_addr/rd_addr post-increment after each data access
// PORTS
//  clk       in   1   single clock, all logic on rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  din       in   10  command word from SPI slave rx_data
//  rx_valid  in   1   word valid from SPI slave; level, may stay high several cycles
//  dout      out  8   read data to SPI slave tx_data
//  tx_valid  out  1   dout valid to SPI slave
//  cmd_err   out  1   one-cycle pulse: command rejected
// BEHAVIOUR
//  Reset:
//  - dout=0, tx_valid=0, cmd_err=0.
//  - wr_addr=0, rd_addr=0, rd_armed=0, rx_valid_d=0.
//  - Memory contents are not cleared; reset mid-operation aborts the access in flight.
//  Acceptance:
//  - A word is accepted only on the cycle where rx_valid=1 and rx_valid_d=0 (rising edge).
//  - rx_valid_d <= rx_valid every cycle.
//  - Holding rx_valid high never repeats a command.
//  Range check: applies to address-bearing commands 00, 10 and data accesses 01, 11.
//  - If the target address >= MEM_DEPTH: cmd_err pulses 1 cycle after acceptance.
//  - No state changes; no memory write; no tx_valid.
//  Commands, evaluated at the accept edge:
//  - 00 WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0]. din[7:ADDR_SIZE] must be 0, else cmd_err.
//  - 01 WR_DATA: mem[wr_addr] <= din[7:0]. If AUTO_INC: wr_addr <= wr_addr+1, wrapping MEM_DEPTH-1 -> 0.
//  - 10 RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0]; rd_armed <= 1. Upper-bit rule as 00.
//  - 11 RD_DATA, rd_armed=1:
//      dout <= mem[rd_addr], visible 1 cycle after acceptance; tx_valid <= 1 in the same cycle.
//      AUTO_INC=0: rd_armed <= 0.
//      AUTO_INC=1: rd_addr <= rd_addr+1 with wrap; rd_armed stays 1.
//  - 11 RD_DATA, rd_armed=0: cmd_err pulse; dout and tx_valid unchanged.
//  tx_valid and dout:
//  - tx_valid holds 1 until the next accepted word, then drops to 0 the cycle after that acceptance.
//  - Exception: a back-to-back 11 keeps tx_valid=1 with updated dout.
//  - dout is stable whenever tx_valid=1 and changes only on a successful 11.
//  Hazards:
//  - A write to rd_addr followed by 11 returns the newly written byte.
//  - No read-during-write hazard: one access per accepted word.
//  Latency: all effects 1 clk after the accept edge; throughput 1 word per rx_valid pulse.
//  State: FSM IDLE -> ACCEPT -> IDLE. IDLE waits for the rx_valid edge; ACCEPT decodes for exactly 1 cycle.
// TESTING
//  T1 reset: rst_n=0 mid-write -> dout=0, tx_valid=0, cmd_err=0, rd_armed=0; prior memory preserved.
//  T2 write/read: words 0x005, 0x1A5, 0x205, 0x3xx -> 1 clk after last accept dout=0xA5, tx_valid=1;
//     next accepted word drops tx_valid.
//  T3 level rx_valid: rx_valid held 4 cycles on 0x1C3 -> exactly one write.
//     With AUTO_INC=1, wr_addr advances by 1 only.
//  T4 unarmed read: 0x300 after reset, or a second 0x300 with AUTO_INC=0 -> cmd_err 1-cycle pulse;
//     tx_valid=0, dout unchanged.
//  T5 range/wrap: MEM_DEPTH=16, ADDR_SIZE=4: 0x020 -> cmd_err, wr_addr unchanged.
//     AUTO_INC=1, writes at 0x00F -> wr_addr wraps to 0.
//  T6 RAW: write 0x3C to rd_addr via 00/01, then 11 -> dout=0x3C.
//     Back-to-back 11 with AUTO_INC=1 keeps tx_valid=1 with successive bytes.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
// ----------------------------------------------------------------------------
// spi_ram_ctrl
//   Command-decoding single-port RAM that sits behind an SPI slave. Each
//   10-bit word from the slave carries a 2-bit command in din[9:8] and an
//   address or data byte in din[7:0]. The controller loads the write and read
//   address registers, writes data bytes and returns read bytes to the slave.
//
// Parameters
//   MEM_DEPTH  number of 8-bit words (2..256)
//   ADDR_SIZE  address register width (2**ADDR_SIZE >= MEM_DEPTH, <= 8)
//   AUTO_INC   1: wr_addr / rd_addr post-increment after each data access
//
// Ports
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   din       in   10  command word from the SPI slave
//   rx_valid  in   1   word valid (level); only its rising edge is accepted
//   dout      out  8   read data to the SPI slave
//   tx_valid  out  1   dout valid
//   cmd_err   out  1   one-cycle pulse when a command is rejected
// ----------------------------------------------------------------------------
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    typedef enum logic {
        IDLE,
        ACCEPT
    } state_t;

    localparam logic [8:0] DEPTH9 = 9'(MEM_DEPTH);

    state_t               state, state_nxt;
    logic                 rx_valid_d;
    logic [ADDR_SIZE-1:0] wr_addr, wr_addr_nxt;
    logic [ADDR_SIZE-1:0] rd_addr, rd_addr_nxt;
    logic                 rd_armed, rd_armed_nxt;
    logic [7:0]           dout_nxt;
    logic                 tx_valid_nxt;
    logic                 cmd_err_nxt;
    logic                 mem_we;
    logic                 accept;
    logic                 din_addr_ok;
    logic                 wr_addr_ok;
    logic                 rd_addr_ok;

    logic [7:0] mem [MEM_DEPTH];

    // Post-increment that wraps at MEM_DEPTH, not at 2**ADDR_SIZE.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (9'(a) == DEPTH9 - 9'd1)
            return '0;
        else
            return a + ADDR_SIZE'(1);
    endfunction

    // Comparing the whole byte against MEM_DEPTH also rejects any nonzero
    // bits above ADDR_SIZE, since 2**ADDR_SIZE >= MEM_DEPTH.
    assign din_addr_ok = ({1'b0, din[7:0]} < DEPTH9);
    assign wr_addr_ok  = (9'(wr_addr) < DEPTH9);
    assign rd_addr_ok  = (9'(rd_addr) < DEPTH9);

    // Gating with rst_n keeps a word arriving during reset from writing memory.
    assign accept = rst_n && (state == IDLE) && rx_valid && !rx_valid_d;

    always_comb begin
        state_nxt    = IDLE;
        wr_addr_nxt  = wr_addr;
        rd_addr_nxt  = rd_addr;
        rd_armed_nxt = rd_armed;
        dout_nxt     = dout;
        tx_valid_nxt = tx_valid;
        cmd_err_nxt  = 1'b0;
        mem_we       = 1'b0;

        if (accept) begin
            state_nxt    = ACCEPT;
            // Any accepted word drops tx_valid unless it is itself a good read.
            tx_valid_nxt = 1'b0;
            case (din[9:8])
                2'b00: begin
                    if (din_addr_ok) wr_addr_nxt = din[ADDR_SIZE-1:0];
                    else             cmd_err_nxt = 1'b1;
                end
                2'b01: begin
                    if (wr_addr_ok) begin
                        mem_we = 1'b1;
                        if (AUTO_INC != 0) wr_addr_nxt = next_addr(wr_addr);
                    end else begin
                        cmd_err_nxt = 1'b1;
                    end
                end
                2'b10: begin
                    if (din_addr_ok) begin
                        rd_addr_nxt  = din[ADDR_SIZE-1:0];
                        rd_armed_nxt = 1'b1;
                    end else begin
                        cmd_err_nxt = 1'b1;
                    end
                end
                default: begin
                    if (rd_armed && rd_addr_ok) begin
                        dout_nxt     = mem[rd_addr];
                        tx_valid_nxt = 1'b1;
                        if (AUTO_INC != 0) rd_addr_nxt  = next_addr(rd_addr);
                        else               rd_armed_nxt = 1'b0;
                    end else begin
                        cmd_err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rx_valid_d <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_armed   <= 1'b0;
            dout       <= '0;
            tx_valid   <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            rx_valid_d <= rx_valid;
            wr_addr    <= wr_addr_nxt;
            rd_addr    <= rd_addr_nxt;
            rd_armed   <= rd_armed_nxt;
            dout       <= dout_nxt;
            tx_valid   <= tx_valid_nxt;
            cmd_err    <= cmd_err_nxt;
        end
    end

    // Memory has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= din[7:0];
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_ram_ctrl
//   Drives two controllers from the same word stream: a 256-word instance
//   without auto-increment and a 16-word instance with auto-increment. Each
//   instance is compared against a command-level reference model.
// ----------------------------------------------------------------------------
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout0, dout1;
    logic       txv0, txv1;
    logic       err0, err1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout0), .tx_valid(txv0), .cmd_err(err0)
    );

    spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_SIZE(4), .AUTO_INC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout1), .tx_valid(txv1), .cmd_err(err1)
    );

    // Reference model, one entry per instance.
    int         m_depth [2] = '{256, 16};
    bit         m_ainc  [2] = '{1'b0, 1'b1};
    logic [7:0] m_mem   [2][256];
    int         m_wa    [2];
    int         m_ra    [2];
    bit         m_armed [2];
    logic [7:0] m_dout  [2];
    bit         m_txv   [2];
    bit         m_err   [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wa[i] = 0; m_ra[i] = 0; m_armed[i] = 1'b0;
            m_dout[i] = 8'h00; m_txv[i] = 1'b0; m_err[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(input logic [9:0] w);
        for (int i = 0; i < 2; i++) begin
            int v;
            v = int'(w[7:0]);
            m_err[i] = 1'b0;
            m_txv[i] = 1'b0;
            case (w[9:8])
                2'd0: if (v < m_depth[i]) m_wa[i] = v; else m_err[i] = 1'b1;
                2'd1: begin
                    m_mem[i][m_wa[i]] = w[7:0];
                    if (m_ainc[i]) m_wa[i] = (m_wa[i] + 1) % m_depth[i];
                end
                2'd2: begin
                    if (v < m_depth[i]) begin
                        m_ra[i] = v; m_armed[i] = 1'b1;
                    end else begin
                        m_err[i] = 1'b1;
                    end
                end
                default: begin
                    if (m_armed[i]) begin
                        m_dout[i] = m_mem[i][m_ra[i]];
                        m_txv[i]  = 1'b1;
                        if (m_ainc[i]) m_ra[i] = (m_ra[i] + 1) % m_depth[i];
                        else           m_armed[i] = 1'b0;
                    end else begin
                        m_err[i] = 1'b1;
                    end
                end
            endcase
        end
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".dout0"}, 32'(dout0), 32'(m_dout[0]));
        check_eq({tag, ".txv0"},  32'(txv0),  32'(m_txv[0]));
        check_eq({tag, ".err0"},  32'(err0),  32'(m_err[0]));
        check_eq({tag, ".dout1"}, 32'(dout1), 32'(m_dout[1]));
        check_eq({tag, ".txv1"},  32'(txv1),  32'(m_txv[1]));
        check_eq({tag, ".err1"},  32'(err1),  32'(m_err[1]));
    endtask

    // Called at a falling edge with rx_valid low; returns at a falling edge.
    task automatic send(input logic [9:0] w, input int hold);
        din      = w;
        rx_valid = 1'b1;
        @(negedge clk);
        model_step(w);
        check_outputs("acc");
        for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            m_err[0] = 1'b0; m_err[1] = 1'b0;
            check_outputs("hold");
        end
        rx_valid = 1'b0;
        din      = 10'($urandom);
        @(negedge clk);
        m_err[0] = 1'b0; m_err[1] = 1'b0;
        check_outputs("gap");
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("post_reset");

        // Unarmed read straight after reset.
        send(10'h300, 1);
        check_eq("t4.err0", 32'(m_err[0]), 32'd0);

        // Fill every location so later reads have defined contents.
        for (int a = 0; a < 256; a++) begin
            send(10'(a), 1);
            send(10'h100 | 10'((a ^ 8'h5A) & 8'hFF), 1);
        end

        // Write then read back at address 5.
        send(10'h005, 1);
        send(10'h1A5, 1);
        send(10'h205, 1);
        send(10'h3FF, 1);
        check_eq("t2.dout0", 32'(dout0), 32'hA5);
        check_eq("t2.txv0",  32'(txv0),  32'd1);
        check_eq("t2.dout1", 32'(dout1), 32'hA5);
        send(10'h000, 1);
        check_eq("t2.drop0", 32'(txv0), 32'd0);

        // Reset during a pending write: outputs clear, write is abandoned.
        send(10'h205, 1);
        send(10'h300, 1);
        send(10'h005, 1);
        din      = 10'h1EE;
        rx_valid = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs("t1.rst");
        @(negedge clk);
        rx_valid = 1'b0;
        check_outputs("t1.hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("t1.rel");
        send(10'h300, 1);
        send(10'h205, 1);
        send(10'h300, 1);
        check_eq("t1.mem0", 32'(dout0), 32'hA5);

        // Second read without re-arming.
        send(10'h300, 2);

        // Level rx_valid must not repeat the write.
        send(10'h003, 1);
        send(10'h1C3, 4);
        send(10'h1D4, 3);
        send(10'h203, 1);
        send(10'h300, 4);
        send(10'h300, 1);

        // Range check and wrap on the 16-word instance.
        send(10'h020, 1);
        send(10'h00F, 1);
        send(10'h111, 1);
        send(10'h122, 1);
        send(10'h20F, 1);
        send(10'h300, 1);
        send(10'h300, 1);
        check_eq("t5.wrap1", 32'(dout1), 32'h22);

        // Read-after-write through rd_addr, then back-to-back reads.
        send(10'h207, 1);
        send(10'h007, 1);
        send(10'h13C, 1);
        send(10'h300, 1);
        check_eq("t6.raw0", 32'(dout0), 32'h3C);
        check_eq("t6.raw1", 32'(dout1), 32'h3C);
        send(10'h300, 1);
        send(10'h300, 1);
        send(10'h300, 1);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            logic [1:0] cmd;
            logic [7:0] val;
            cmd = 2'($urandom);
            val = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15))
                                              : 8'($urandom_range(0, 255));
            send({cmd, val}, $urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
